tpu_job_sequencer: RTL and testbench

- Host-side initiator for the systolic-array top level. Executes one matrix-multiply job end to end.
- Loads a WIDTH_HEIGHT-row weight tile and input tile from a valid/ready stream into the weight and input memories.
- Pulses fill_fifo, then drain_fifo, then active, waiting on each done flag in turn.
- Streams the WIDTH_HEIGHT result rows out of the output memory over a valid/ready stream.

---
 rtl/tpu_job_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_tpu_job_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_job_sequencer.sv
// Host-side job sequencer for the systolic-array top: loads the weight and input tiles,
// steps the fill/drain/run handshakes, then streams the result tile back to the host.
module tpu_job_sequencer #(
    parameter int WIDTH_HEIGHT = 16,
    parameter int TIMEOUT      = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [7:0]                   in_base,
    input  logic [7:0]                   wt_base,
    input  logic [7:0]                   out_base,
    input  logic                         ld_valid,
    output logic                         ld_ready,
    input  logic [WIDTH_HEIGHT*8-1:0]    ld_data,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [WIDTH_HEIGHT*16-1:0]   res_data,
    output logic                         busy,
    output logic                         job_done,
    output logic                         err,
    output logic [WIDTH_HEIGHT-1:0]      inputMem_wr_en,
    output logic [WIDTH_HEIGHT*8-1:0]    inputMem_wr_addr,
    output logic [WIDTH_HEIGHT*8-1:0]    inputMem_wr_data,
    output logic [WIDTH_HEIGHT-1:0]      weightMem_wr_en,
    output logic [WIDTH_HEIGHT*8-1:0]    weightMem_wr_addr,
    output logic [WIDTH_HEIGHT*8-1:0]    weightMem_wr_data,
    output logic [WIDTH_HEIGHT*8-1:0]    inputMem_rd_addr_base,
    output logic [WIDTH_HEIGHT*8-1:0]    weightMem_rd_addr_base,
    output logic [WIDTH_HEIGHT*8-1:0]    outputMem_wr_addr_base,
    output logic [WIDTH_HEIGHT-1:0]      outputMem_rd_en,
    output logic [WIDTH_HEIGHT*8-1:0]    outputMem_rd_addr,
    input  logic [WIDTH_HEIGHT*16-1:0]   outputMem_rd_data,
    output logic                         fill_fifo,
    output logic                         drain_fifo,
    output logic                         active,
    input  logic                         mem_to_fifo_done,
    input  logic                         fifo_to_arr_done,
    input  logic                         output_done
);
    localparam int              TW       = $clog2(TIMEOUT) + 1;
    localparam logic [7:0]      LAST_ROW = 8'(WIDTH_HEIGHT - 1);
    localparam logic [8:0]      ROWS     = 9'(WIDTH_HEIGHT);
    localparam logic [TW-1:0]   T_LAST   = TW'(TIMEOUT - 2);

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0, ST_LD_W = 4'd1, ST_LD_I = 4'd2, ST_FILL = 4'd3,
        ST_W_FILL = 4'd4, ST_DRAIN = 4'd5, ST_W_DRAIN = 4'd6, ST_RUN = 4'd7,
        ST_W_RUN = 4'd8, ST_RD = 4'd9, ST_ERR = 4'd10
    } state_t;

    state_t                      state_q, state_d;
    logic [7:0]                  row_q, in_base_q, wt_base_q, out_base_q;
    logic [TW-1:0]               timer_q;
    logic                        err_q, job_done_q;
    logic [8:0]                  iss_q, pop_q;
    logic [1:0]                  cnt_q;
    logic                        inflight_q, wr_ptr_q, rd_ptr_q;
    logic [WIDTH_HEIGHT*16-1:0]  fifo_q [2];

    logic       beat_s, pop_s, issue_s, last_row_s, timeout_s;
    logic [2:0] occ_s;
    logic [7:0] wt_row_addr_s, in_row_addr_s, rd_row_addr_s;

    assign beat_s        = ld_ready & ld_valid;
    assign pop_s         = res_valid & res_ready;
    assign last_row_s    = (row_q == LAST_ROW);
    assign timeout_s     = (timer_q == T_LAST);
    assign wt_row_addr_s = wt_base_q + row_q;
    assign in_row_addr_s = in_base_q + row_q;
    assign rd_row_addr_s = out_base_q + iss_q[7:0];
    // A same-cycle pop frees its slot so the stream sustains one row per cycle.
    assign occ_s   = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop_s};
    assign issue_s = (state_q == ST_RD) && (iss_q < ROWS) && (occ_s < 3'd2);

    assign res_data               = fifo_q[rd_ptr_q];
    assign job_done               = job_done_q;
    assign err                    = err_q;
    assign inputMem_rd_addr_base  = {WIDTH_HEIGHT{in_base_q}};
    assign weightMem_rd_addr_base = {WIDTH_HEIGHT{wt_base_q}};
    assign outputMem_wr_addr_base = {WIDTH_HEIGHT{out_base_q}};

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; done flags are only looked at in the wait states
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_LD_W; else state_d = ST_IDLE;
            ST_LD_W:    if (beat_s && last_row_s) state_d = ST_LD_I; else state_d = ST_LD_W;
            ST_LD_I:    if (beat_s && last_row_s) state_d = ST_FILL; else state_d = ST_LD_I;
            ST_FILL:    state_d = ST_W_FILL;
            ST_W_FILL:  if (mem_to_fifo_done) state_d = ST_DRAIN;
                        else if (timeout_s) state_d = ST_ERR;
                        else state_d = ST_W_FILL;
            ST_DRAIN:   state_d = ST_W_DRAIN;
            ST_W_DRAIN: if (fifo_to_arr_done) state_d = ST_RUN;
                        else if (timeout_s) state_d = ST_ERR;
                        else state_d = ST_W_DRAIN;
            ST_RUN:     state_d = ST_W_RUN;
            ST_W_RUN:   if (output_done) state_d = ST_RD;
                        else if (timeout_s) state_d = ST_ERR;
                        else state_d = ST_W_RUN;
            ST_RD:      if (pop_s && (pop_q == ROWS - 9'd1)) state_d = ST_IDLE; else state_d = ST_RD;
            ST_ERR:     state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output decode: pulses, handshakes and memory-port drive
    always_comb begin
        ld_ready          = 1'b0;
        fill_fifo         = 1'b0;
        drain_fifo        = 1'b0;
        active            = 1'b0;
        busy              = (state_q != ST_IDLE);
        res_valid         = 1'b0;
        weightMem_wr_en   = '0;
        weightMem_wr_addr = '0;
        weightMem_wr_data = '0;
        inputMem_wr_en    = '0;
        inputMem_wr_addr  = '0;
        inputMem_wr_data  = '0;
        outputMem_rd_en   = '0;
        outputMem_rd_addr = '0;
        case (state_q)
            ST_LD_W: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    weightMem_wr_en   = '1;
                    weightMem_wr_addr = {WIDTH_HEIGHT{wt_row_addr_s}};
                    weightMem_wr_data = ld_data;
                end else begin
                    weightMem_wr_en   = '0;
                end
            end
            ST_LD_I: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    inputMem_wr_en   = '1;
                    inputMem_wr_addr = {WIDTH_HEIGHT{in_row_addr_s}};
                    inputMem_wr_data = ld_data;
                end else begin
                    inputMem_wr_en   = '0;
                end
            end
            ST_FILL:  fill_fifo  = 1'b1;
            ST_DRAIN: drain_fifo = 1'b1;
            ST_RUN:   active     = 1'b1;
            ST_RD: begin
                res_valid = (cnt_q != 2'd0);
                if (issue_s) begin
                    outputMem_rd_en   = '1;
                    outputMem_rd_addr = {WIDTH_HEIGHT{rd_row_addr_s}};
                end else begin
                    outputMem_rd_en   = '0;
                end
            end
            default: busy = (state_q != ST_IDLE);
        endcase
    end

    // Job control: latched bases, load row counter, wait timer, err and job_done flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_base_q  <= 8'd0;
            wt_base_q  <= 8'd0;
            out_base_q <= 8'd0;
            row_q      <= 8'd0;
            timer_q    <= '0;
            err_q      <= 1'b0;
            job_done_q <= 1'b0;
        end else begin
            job_done_q <= (state_q == ST_RD) && (state_d == ST_IDLE);
            case (state_q)
                ST_IDLE: if (start) begin
                    in_base_q  <= in_base;
                    wt_base_q  <= wt_base;
                    out_base_q <= out_base;
                    err_q      <= 1'b0;
                    row_q      <= 8'd0;
                end
                ST_LD_W, ST_LD_I: if (beat_s) row_q <= last_row_s ? 8'd0 : row_q + 8'd1;
                ST_FILL, ST_DRAIN, ST_RUN: timer_q <= '0;
                ST_W_FILL, ST_W_DRAIN, ST_W_RUN: begin
                    timer_q <= timer_q + TW'(1);
                    if (state_d == ST_ERR) err_q <= 1'b1;
                end
                default: timer_q <= timer_q;
            endcase
        end
    end

    // Result path: read issue, one-cycle-latency capture into the 2-entry FIFO, pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iss_q      <= 9'd0;
            pop_q      <= 9'd0;
            cnt_q      <= 2'd0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
        end else if ((state_q == ST_IDLE) && start) begin
            iss_q      <= 9'd0;
            pop_q      <= 9'd0;
            cnt_q      <= 2'd0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else begin
            inflight_q <= issue_s;
            cnt_q      <= cnt_q + {1'b0, inflight_q} - {1'b0, pop_s};
            if (issue_s) iss_q <= iss_q + 9'd1;
            if (inflight_q) begin
                fifo_q[wr_ptr_q] <= outputMem_rd_data;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= ~rd_ptr_q;
                pop_q    <= pop_q + 9'd1;
            end
        end
    end
endmodule

// File: tb/tb_tpu_job_sequencer.sv
// Directed bench for tpu_job_sequencer (4x4 array, 8-cycle timeout) with a small
// output-memory model whose read data encodes the address it was read from.
module tb_tpu_job_sequencer;
    localparam int WH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, ld_valid, res_ready;
    logic [7:0] in_base, wt_base, out_base;
    logic [WH*8-1:0] ld_data;
    logic mem_to_fifo_done, fifo_to_arr_done, output_done;
    logic ld_ready, res_valid, busy, job_done, err, fill_fifo, drain_fifo, active;
    logic [WH*16-1:0] res_data;
    logic [WH*16-1:0] mem_rd_data = '0;
    logic [WH-1:0] inputMem_wr_en, weightMem_wr_en, outputMem_rd_en;
    logic [WH*8-1:0] inputMem_wr_addr, inputMem_wr_data, weightMem_wr_addr, weightMem_wr_data;
    logic [WH*8-1:0] inputMem_rd_addr_base, weightMem_rd_addr_base, outputMem_wr_addr_base;
    logic [WH*8-1:0] outputMem_rd_addr;

    int tests = 0;
    int fails = 0;
    bit bp_tbl [12] = '{1, 0, 0, 1, 1, 0, 1, 0, 0, 1, 1, 1};

    tpu_job_sequencer #(.WIDTH_HEIGHT(WH), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_base(in_base), .wt_base(wt_base), .out_base(out_base),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy), .job_done(job_done), .err(err),
        .inputMem_wr_en(inputMem_wr_en), .inputMem_wr_addr(inputMem_wr_addr),
        .inputMem_wr_data(inputMem_wr_data),
        .weightMem_wr_en(weightMem_wr_en), .weightMem_wr_addr(weightMem_wr_addr),
        .weightMem_wr_data(weightMem_wr_data),
        .inputMem_rd_addr_base(inputMem_rd_addr_base),
        .weightMem_rd_addr_base(weightMem_rd_addr_base),
        .outputMem_wr_addr_base(outputMem_wr_addr_base),
        .outputMem_rd_en(outputMem_rd_en), .outputMem_rd_addr(outputMem_rd_addr),
        .outputMem_rd_data(mem_rd_data),
        .fill_fifo(fill_fifo), .drain_fifo(drain_fifo), .active(active),
        .mem_to_fifo_done(mem_to_fifo_done), .fifo_to_arr_done(fifo_to_arr_done),
        .output_done(output_done)
    );

    logic all_or;
    assign all_or = |{ld_ready, res_valid, res_data, busy, job_done, err,
                      inputMem_wr_en, inputMem_wr_addr, inputMem_wr_data,
                      weightMem_wr_en, weightMem_wr_addr, weightMem_wr_data,
                      inputMem_rd_addr_base, weightMem_rd_addr_base, outputMem_wr_addr_base,
                      outputMem_rd_en, outputMem_rd_addr, fill_fifo, drain_fifo, active};

    // Output memory: each bank returns {row address, 0xA0+bank} one cycle after rd_en
    always @(posedge clk) begin
        if (outputMem_rd_en[0]) begin
            for (int i = 0; i < WH; i++)
                mem_rd_data[i*16 +: 16] <= {outputMem_rd_addr[i*8 +: 8], 8'(8'hA0 + i)};
        end
    end

    function automatic logic [WH*16-1:0] exp_row(input logic [7:0] base, input int r);
        logic [WH*16-1:0] v;
        for (int i = 0; i < WH; i++) v[i*16 +: 16] = {8'(base + r), 8'(8'hA0 + i)};
        return v;
    endfunction

    function automatic logic [WH*8-1:0] ld_row(input bit wsel, input int r);
        logic [WH*8-1:0] v;
        for (int i = 0; i < WH; i++) v[i*8 +: 8] = 8'((wsel ? 8'hC0 : 8'h40) + r * 4 + i);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [7:0] ib, input logic [7:0] wb, input logic [7:0] ob);
        @(negedge clk);
        ld_valid = 1'b0; res_ready = 1'b0;
        {mem_to_fifo_done, fifo_to_arr_done, output_done} = 3'b000;
        start = 1'b1; in_base = ib; wt_base = wb; out_base = ob;
        #1;
        chk("idle_busy", busy, 1'b0);
    endtask

    task automatic load(input bit wsel, input logic [7:0] base, input int gap_at, input bit poke);
        for (int r = 0; r < WH; r++) begin
            if (r == gap_at) begin
                @(negedge clk);
                start = 1'b0; ld_valid = 1'b0;
                #1;
                chk("ld_ready_gap", ld_ready, 1'b1);
                chk("no_write_gap", {weightMem_wr_en, inputMem_wr_en}, 8'h00);
            end
            @(negedge clk);
            start = poke && (r == 1);
            if (poke && r == 1) begin
                in_base = 8'h99; wt_base = 8'h99; out_base = 8'h99;
            end
            ld_valid = 1'b1;
            ld_data  = ld_row(wsel, r);
            #1;
            if (wsel && r == 0) chk("err_cleared", err, 1'b0);
            chk("ld_ready", ld_ready, 1'b1);
            chk("wt_wr_en", weightMem_wr_en, wsel ? 4'hF : 4'h0);
            chk("in_wr_en", inputMem_wr_en, wsel ? 4'h0 : 4'hF);
            chk("wr_addr", wsel ? weightMem_wr_addr : inputMem_wr_addr, {4{8'(base + r)}});
            chk("wr_data", wsel ? weightMem_wr_data : inputMem_wr_data, ld_row(wsel, r));
        end
    endtask

    task automatic phase(input int which);
        @(negedge clk);
        ld_valid = 1'b0; start = 1'b0;
        {mem_to_fifo_done, fifo_to_arr_done, output_done} = 3'b000;
        #1;
        chk("pulse_on", {fill_fifo, drain_fifo, active}, 3'b100 >> which);
        chk("ld_ready_off", ld_ready, 1'b0);
        chk("res_valid_off", res_valid, 1'b0);
        @(negedge clk); #1;
        chk("pulse_single", {fill_fifo, drain_fifo, active}, 3'b000);
        @(negedge clk);
        @(negedge clk);
        {mem_to_fifo_done, fifo_to_arr_done, output_done} = 3'b100 >> which;
    endtask

    task automatic read_res(input logic [7:0] base, input bit bp, input bit poke);
        int iss = 0;
        int pop = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        logic [WH*16-1:0] held = '0;
        while (pop < WH && cyc < 60) begin
            @(negedge clk);
            {mem_to_fifo_done, fifo_to_arr_done, output_done} = 3'b000;
            start = poke && (cyc == 3);
            if (poke && cyc == 3) begin
                in_base = 8'h77; wt_base = 8'h77; out_base = 8'h77;
            end
            res_ready = bp ? bp_tbl[cyc % 12] : 1'b1;
            #1;
            if (stalled) begin
                chk("hold_valid", res_valid, 1'b1);
                chk("hold_data", res_data, held);
            end
            if (outputMem_rd_en != '0) begin
                chk("rd_en", outputMem_rd_en, 4'hF);
                chk("rd_issue_limit", iss < WH, 1'b1);
                chk("rd_addr", outputMem_rd_addr, {4{8'(base + iss)}});
                iss++;
            end
            if (res_valid && res_ready) begin
                chk("res_data", res_data, exp_row(base, pop));
                pop++;
            end
            chk("outstanding_le2", (iss - pop) <= 2, 1'b1);
            stalled = res_valid && !res_ready;
            held = res_data;
            cyc++;
        end
        chk("rd_all_rows", pop, WH);
        @(negedge clk);
        start = 1'b0; res_ready = 1'b0;
        #1;
        chk("job_done", job_done, 1'b1);
        chk("busy_fall", busy, 1'b0);
        @(negedge clk); #1;
        chk("job_done_pulse", job_done, 1'b0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; ld_valid = 1'b0; res_ready = 1'b0;
        in_base = 8'h0; wt_base = 8'h0; out_base = 8'h0; ld_data = '0;
        {mem_to_fifo_done, fifo_to_arr_done, output_done} = 3'b000;
        #12;
        chk("rst_outs_zero", all_or, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        @(negedge clk); reset = 1'b1;

        // Job A: plain job with a one-cycle gap in the weight stream
        start_job(8'h10, 8'h20, 8'h30);
        load(1'b1, 8'h20, 2, 1'b0);
        load(1'b0, 8'h10, -1, 1'b0);
        chk("in_base_out", inputMem_rd_addr_base, {4{8'h10}});
        chk("wt_base_out", weightMem_rd_addr_base, {4{8'h20}});
        chk("out_base_out", outputMem_wr_addr_base, {4{8'h30}});
        phase(0); phase(1); phase(2);
        read_res(8'h30, 1'b0, 1'b0);

        // Job B: weight address wrap, ignored starts, result backpressure
        start_job(8'h40, 8'hFE, 8'h60);
        load(1'b1, 8'hFE, -1, 1'b0);
        load(1'b0, 8'h40, -1, 1'b1);
        phase(0); phase(1); phase(2);
        read_res(8'h60, 1'b1, 1'b1);
        chk("base_hold_in", inputMem_rd_addr_base, {4{8'h40}});
        chk("base_hold_wt", weightMem_rd_addr_base, {4{8'hFE}});
        chk("base_hold_out", outputMem_wr_addr_base, {4{8'h60}});

        // Job C: fifo_to_arr_done never arrives
        start_job(8'h00, 8'h08, 8'h70);
        load(1'b1, 8'h08, -1, 1'b0);
        load(1'b0, 8'h00, -1, 1'b0);
        phase(0);
        @(negedge clk);
        {mem_to_fifo_done, fifo_to_arr_done, output_done} = 3'b000;
        #1;
        chk("drain_pulse", {fill_fifo, drain_fifo, active}, 3'b010);
        repeat (6) @(negedge clk);
        @(negedge clk); #1;
        chk("err_early", err, 1'b0);
        @(negedge clk); #1;
        chk("err_at_8", err, 1'b1);
        chk("busy_in_err", busy, 1'b1);
        @(negedge clk); #1;
        chk("err_idle", busy, 1'b0);
        chk("err_sticky", err, 1'b1);
        chk("no_active", active, 1'b0);

        // Job D: the next start clears err and completes
        start_job(8'h11, 8'h22, 8'h33);
        chk("err_until_start", err, 1'b1);
        load(1'b1, 8'h22, -1, 1'b0);
        load(1'b0, 8'h11, -1, 1'b0);
        phase(0); phase(1); phase(2);
        read_res(8'h33, 1'b1, 1'b0);

        // Job E: reset in the middle of the result stream
        start_job(8'h01, 8'h02, 8'h30);
        load(1'b1, 8'h02, -1, 1'b0);
        load(1'b0, 8'h01, -1, 1'b0);
        phase(0); phase(1); phase(2);
        repeat (4) begin
            @(negedge clk);
            {mem_to_fifo_done, fifo_to_arr_done, output_done} = 3'b000;
            res_ready = 1'b1;
        end
        #3 reset = 1'b0;
        #1;
        chk("midrd_rst_zero", all_or, 1'b0);
        chk("midrd_rst_busy", busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1; res_ready = 1'b0;

        // Job F: fresh job after reset, no stale result rows
        start_job(8'h05, 8'h06, 8'h50);
        load(1'b1, 8'h06, -1, 1'b0);
        load(1'b0, 8'h05, -1, 1'b0);
        phase(0); phase(1); phase(2);
        read_res(8'h50, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
